// File: rtl/mux81_rr_arbiter_pkg.sv
// Shared types, constants and the rotating-priority pick function
// for the 8:1 mux round-robin arbiter.
package mux81_arb_pkg;

    localparam int NUM_REQ = 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef logic [2:0] sel_t;

    typedef struct packed {
        logic found;
        sel_t idx;
    } pick_t;

    // Scans from the highest offset down, so the lowest offset from ptr is kept.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req, input sel_t ptr);
        pick_t r;
        sel_t  k;
        r = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = ptr + sel_t'(i);
            if (req[k]) begin
                r.found = 1'b1;
                r.idx   = k;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mux81.sv
// Behavioral 8:1 single-bit mux shared by the arbiter's requesters.
module mux81 (
    input  logic [7:0] d,
    input  logic [2:0] s,
    output logic       o
);

    assign o = d[s];

endmodule

// File: rtl/mux81_rr_arbiter.sv
// Round-robin arbiter granting one of eight requesters access to a shared
// 8:1 mux, with each grant capped at MAX_HOLD cycles.
module mux81_rr_arbiter
    import mux81_arb_pkg::*;
#(
    parameter  int MAX_HOLD = 4,
    localparam int CNT_W    = $clog2(MAX_HOLD) + 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] din,
    output logic [7:0] gnt,
    output logic [2:0] sel,
    output logic       busy,
    output logic       y
);

    state_t           state_q, state_d;
    sel_t             sel_q, sel_d;
    sel_t             ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_q, hold_d;

    logic  release_grant;
    sel_t  scan_ptr;
    pick_t pick;
    logic  mux_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    // On release the scan starts just past the outgoing winner, so the
    // next grant follows without an idle bubble.
    always_comb begin
        release_grant = (state_q == BUSY) &&
                        (!req[sel_q] || (hold_q == CNT_W'(MAX_HOLD - 1)));
        scan_ptr      = release_grant ? sel_q + 3'd1 : ptr_q;
        pick          = rr_pick(req, scan_ptr);

        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            IDLE: begin
                if (pick.found) begin
                    state_d = BUSY;
                    sel_d   = pick.idx;
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (release_grant) begin
                    ptr_d  = scan_ptr;
                    hold_d = '0;
                    if (pick.found) begin
                        sel_d = pick.idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_d = hold_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = '0;
            end
        endcase
    end

    mux81 u_mux (
        .d (din),
        .s (sel_q),
        .o (mux_out)
    );

    assign busy = (state_q == BUSY);
    assign sel  = sel_q;
    assign gnt  = busy ? (8'b1 << sel_q) : 8'b0;
    assign y    = mux_out & busy;

endmodule

// File: tb/tb_mux81_rr_arbiter.sv
// Directed, table-driven bench for mux81_rr_arbiter with MAX_HOLD=4,
// plus hand-written reset and rotation sequences.
module tb_mux81_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] din;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       busy;
    logic       y;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] req;
        logic [7:0] din;
        logic       adv;
        logic [7:0] gnt;
        logic [2:0] sel;
        logic       busy;
        logic       y;
    } vec_t;

    vec_t vecs[$];

    mux81_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .sel   (sel),
        .busy  (busy),
        .y     (y)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic addVec(input logic [7:0] r, input logic [7:0] d, input logic a,
                          input logic [7:0] g, input logic [2:0] s, input logic b,
                          input logic yy);
        vec_t v;
        v.req = r; v.din = d; v.adv = a;
        v.gnt = g; v.sel = s; v.busy = b; v.y = yy;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [7:0] g, input logic [2:0] s,
                               input logic b, input logic yy);
        compare({tag, " gnt"}, int'(gnt), int'(g));
        compare({tag, " busy"}, int'(busy), int'(b));
        compare({tag, " y"}, int'(y), int'(yy));
        if (b) compare({tag, " sel"}, int'(sel), int'(s));
    endtask

    // Drive inputs; when adv is set, step one rising edge before sampling.
    task automatic applyStimulus(input logic [7:0] r, input logic [7:0] d, input logic adv);
        req = r;
        din = d;
        if (adv) @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] rotDin;
        logic [2:0] expSel;

        rst_n = 1'b0;
        req   = 8'h00;
        din   = 8'h00;

        // Single requester 5, then idle return with the request dropping.
        addVec(8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1);
        addVec(8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1);
        addVec(8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1);
        addVec(8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1);
        addVec(8'h20, 8'h20, 1, 8'h20, 3'd5, 1, 1);
        addVec(8'h20, 8'h00, 1, 8'h20, 3'd5, 1, 0);
        addVec(8'h00, 8'hFF, 0, 8'h20, 3'd5, 1, 1);
        addVec(8'h00, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
        // Wrap and skip from ptr=6: requester 0 first, then 1.
        addVec(8'h03, 8'h02, 1, 8'h01, 3'd0, 1, 0);
        addVec(8'h03, 8'h02, 1, 8'h01, 3'd0, 1, 0);
        addVec(8'h03, 8'h02, 1, 8'h01, 3'd0, 1, 0);
        addVec(8'h03, 8'h02, 1, 8'h01, 3'd0, 1, 0);
        addVec(8'h03, 8'h02, 1, 8'h02, 3'd1, 1, 1);
        addVec(8'h00, 8'h00, 1, 8'h00, 3'd0, 0, 0);
        // Early release of requester 3 hands over to 6 with a fresh hold count.
        addVec(8'h08, 8'h08, 1, 8'h08, 3'd3, 1, 1);
        addVec(8'h48, 8'h08, 1, 8'h08, 3'd3, 1, 1);
        addVec(8'h40, 8'h08, 0, 8'h08, 3'd3, 1, 1);
        addVec(8'h40, 8'h40, 1, 8'h40, 3'd6, 1, 1);
        addVec(8'h48, 8'h48, 1, 8'h40, 3'd6, 1, 1);
        addVec(8'h48, 8'h48, 1, 8'h40, 3'd6, 1, 1);
        addVec(8'h48, 8'h48, 1, 8'h40, 3'd6, 1, 1);
        addVec(8'h48, 8'h48, 1, 8'h08, 3'd3, 1, 1);
        addVec(8'h00, 8'hFF, 1, 8'h00, 3'd0, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        compare("reset gnt", int'(gnt), 0);
        compare("reset sel", int'(sel), 0);
        compare("reset busy", int'(busy), 0);
        compare("reset y", int'(y), 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].req, vecs[i].din, vecs[i].adv);
            checkOutput($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].sel,
                        vecs[i].busy, vecs[i].y);
        end

        // All requesting from ptr=4: grant 4, then reset hits mid-grant.
        rotDin = 8'hA5;
        applyStimulus(8'hFF, rotDin, 1);
        checkOutput("pre-reset", 8'h10, 3'd4, 1, rotDin[4]);
        step();
        rst_n = 1'b0;
        #1;
        compare("midreset gnt", int'(gnt), 0);
        compare("midreset sel", int'(sel), 0);
        compare("midreset busy", int'(busy), 0);
        compare("midreset y", int'(y), 0);
        step();
        rst_n = 1'b1;
        step();

        // Full rotation 0..7 then back to 0, four cycles each, no gaps.
        for (int i = 0; i < 36; i++) begin
            expSel = 3'((i / 4) % 8);
            checkOutput($sformatf("rot%0d", i), 8'b1 << expSel, expSel, 1, rotDin[expSel]);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mux81_rr_arbiter.md
Name: mux81_rr_arbiter

Overview:
- Round-robin arbiter that shares one 8:1 single-bit mux between eight requesters.
- Each requester raises a level request. The block grants one requester at a time, drives the mux select with the winner's index, and gates the mux output onto a shared line.
- Each grant is capped at MAX_HOLD cycles for fairness.
- Sits between the requesting sources and the downstream consumer of the shared bit.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant may be held (legal range 1..16).
- CNT_W, $clog2(MAX_HOLD)+1, hold counter width (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req  input  8  level request, bit k = requester k
- din  input  8  data bit from each requester, bit k = requester k
- gnt  output  8  one-hot grant, all-zero when idle
- sel  output  3  mux select, index of the current grant
- busy  output  1  high while a grant is active
- y  output  1  shared data out = din[sel] when busy, else 0

Behaviour:
- Reset (asynchronous, active-low; takes effect mid-operation too):
  - Immediately forces gnt=0, sel=0, busy=0, y=0.
  - Internal: ptr=0, hold_cnt=0, state=IDLE.
- Registered state: state (IDLE, BUSY), sel, ptr (round-robin start index), hold_cnt. gnt is decoded from sel, qualified by busy.
- Arbitration function: scan index ptr, ptr+1, ... ptr+7 modulo 8; the first k with req[k]=1 wins. This is a pure combinational function of req and ptr.
- IDLE:
  - If req is nonzero, the next cycle sets state=BUSY, sel=winner, hold_cnt=0.
  - Otherwise stay in IDLE.
  - Latency: req rising at edge N produces gnt at edge N+1.
- BUSY:
  - y = din[sel] combinationally, through the mux sub-module, each cycle.
  - hold_cnt increments every BUSY cycle.
  - The grant is released when req[sel]=0 or hold_cnt==MAX_HOLD-1.
- Release cycle:
  - ptr <= sel+1, wrapping 7 to 0.
  - Re-arbitrate in the same cycle using the updated ptr value (sel+1) and the current req.
  - If any req is set, load the new winner with hold_cnt=0 and stay in BUSY. This gives back-to-back grants with no idle bubble.
  - If no req is set, go to IDLE: busy=0, gnt=0, y=0.
- Same requester may regain the grant on the next edge only if no other request is pending; with MAX_HOLD=1 a lone requester is therefore granted every cycle.
- Request drop: if req[sel] drops, that cycle is the last granted cycle. y still reflects din[sel] during it.
- Simultaneous requests: only the rotation order decides the winner; there is no fixed priority.
- Unknown or invalid state: recovers to IDLE.
- Fairness guarantee: a continuously asserted request is granted within 7*MAX_HOLD+1 cycles.

Decomposition:
- Package mux81_arb_pkg holds:
  - typedef state_t {IDLE, BUSY}
  - typedef sel_t logic[2:0]
  - constant NUM_REQ=8
  - function rr_pick(req, ptr), returning the winner index and a found flag.
- Sub-module: the existing behavioral 8:1 mux, instantiated with the eight din bits and sel. Its output is ANDed with busy to form y.

Test Plan:
- Reset check: assert rst_n=0 mid-grant while req=8'hFF. Required: gnt=0, sel=0, busy=0, y=0 immediately. First grant goes to requester 0 one cycle after rst_n=1.
- Single requester: req=8'h20 at cycle 0, din=8'h20, MAX_HOLD=4. Required:
  - gnt=8'h20, sel=5, y=1 from cycle 1 through 4.
  - Cycle 4 is the release cycle; re-grant to requester 5 at cycle 5, since no other request.
- Rotation: req=8'hFF held. Required:
  - Grant order 0,1,2,...,7,0, each held exactly 4 cycles with no gap.
  - sel tracks the winner.
- Early release: requester 3 granted, req[3] dropped after 2 cycles while req[6]=1. Required: requester 6 granted on the very next edge, hold_cnt restarted.
- Wrap and skip: ptr=6 (previous grant 5), req=8'h03. Required: grant 0, then 1; not 1 first.
- Idle return: the sole requester drops req. Required: the next cycle gives busy=0, gnt=0, y=0 regardless of din.
